// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared opcodes, geometry defaults and FSM states for the vector memory port
package vec_mem_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b10;

    localparam int WORD_W_DEF    = 32;
    localparam int LANES_DEF     = 16;
    localparam int ADDR_W_DEF    = 9;
    localparam int MEM_DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } vm_state_t;

endpackage

// File: rtl/vec_mem_ctrl.sv
// rtl/vec_mem_ctrl.sv - vector memory port initiator: one 16-lane burst per command, response over valid/ready
module vec_mem_ctrl
    import vec_mem_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [WORD_W*LANES-1:0]   cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_we,
    output logic                      rsp_err,
    output logic [WORD_W*LANES-1:0]   rsp_rdata,
    output logic [1:0]                op_code,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W*LANES-1:0]   mem_wr_data,
    input  logic [WORD_W*LANES-1:0]   mem_rd_data
);

    localparam int DATA_W   = WORD_W * LANES;
    localparam int MAX_BASE = MEM_DEPTH - LANES;
    localparam int CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    vm_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         op_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               valid_nxt;
    logic               we_nxt;
    logic               err_nxt;
    logic [DATA_W-1:0]  rdata_nxt;
    logic               out_of_range;

    // A burst must fit entirely below MEM_DEPTH; nothing ever wraps.
    assign out_of_range = (int'(cmd_addr) > MAX_BASE);
    assign cmd_ready    = (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = OP_NOP;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wr_data;
        valid_nxt = rsp_valid;
        we_nxt    = rsp_we;
        err_nxt   = rsp_err;
        rdata_nxt = rsp_rdata;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_nxt    = cmd_we;
                    rdata_nxt = '0;
                    if (out_of_range) begin
                        state_nxt = ST_RESP;
                        valid_nxt = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_ISSUE;
                        err_nxt   = 1'b0;
                        op_nxt    = cmd_we ? OP_WRITE : OP_READ;
                        addr_nxt  = cmd_addr;
                        wdata_nxt = cmd_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (rsp_we) begin
                    state_nxt = ST_RESP;
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    valid_nxt = 1'b1;
                    rdata_nxt = mem_rd_data;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_code     <= OP_NOP;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            op_code     <= op_nxt;
            mem_addr    <= addr_nxt;
            mem_wr_data <= wdata_nxt;
            rsp_valid   <= valid_nxt;
            rsp_we      <= we_nxt;
            rsp_err     <= err_nxt;
            rsp_rdata   <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// tb/tb_vec_mem_ctrl.sv - self-checking bench for vec_mem_ctrl against a word-array reference model
module tb_vec_mem_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b1;
    logic [8:0]   cmd_addr = '0;
    logic [511:0] cmd_wdata = '0;
    logic         cmd_ready, rsp_valid, rsp_we, rsp_err;
    logic [511:0] rsp_rdata, mem_wr_data, mem_rd_data;
    logic [1:0]   op_code;
    logic [8:0]   mem_addr;

    logic         c2_valid = 1'b0;
    logic [8:0]   c2_addr = '0;
    logic         c2_ready, r2_valid, r2_we, r2_err;
    logic [511:0] r2_rdata, m2_wr_data, m2_rd_data;
    logic [1:0]   op2;
    logic [8:0]   m2_addr;

    logic [31:0]  mem [512];
    logic [31:0]  ref_mem [512];
    logic [511:0] pipe3 [3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vec_mem_ctrl u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .op_code(op_code),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    vec_mem_ctrl #(.RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_we(1'b0),
        .cmd_addr(c2_addr), .cmd_wdata(512'd0), .rsp_valid(r2_valid), .rsp_ready(1'b1),
        .rsp_we(r2_we), .rsp_err(r2_err), .rsp_rdata(r2_rdata), .op_code(op2),
        .mem_addr(m2_addr), .mem_wr_data(m2_wr_data), .mem_rd_data(m2_rd_data)
    );

    function automatic logic [511:0] burst_of(input logic [8:0] a);
        logic [511:0] d = '0;
        for (int j = 0; j < 16; j++)
            if (int'(a) + j < 512) d[j*32 +: 32] = mem[int'(a) + j];
        return d;
    endfunction

    // Memory: write on the sampling edge; reads registered with 1 (u_dut) or 3 (u_dut3) edges of latency.
    always @(posedge clk) begin
        if (op_code == 2'b01)
            for (int j = 0; j < 16; j++)
                if (int'(mem_addr) + j < 512) mem[int'(mem_addr) + j] <= mem_wr_data[j*32 +: 32];
        if (op_code == 2'b00) mem_rd_data <= burst_of(mem_addr);
        pipe3[0] <= (op2 == 2'b00) ? burst_of(m2_addr) : '0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m2_rd_data = pipe3[2];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] ref_burst(input logic [8:0] a);
        logic [511:0] d = '0;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = ref_mem[int'(a) + j];
        return d;
    endfunction

    task automatic txn(input logic we, input logic [8:0] addr, input logic [511:0] wd,
                       input int hold, output logic [511:0] got);
        logic [511:0] exp_data;
        logic exp_err;
        int exp_lat, cyc, n_wr, n_rd;
        exp_err  = (int'(addr) > 496);
        exp_data = (!we && !exp_err) ? ref_burst(addr) : '0;
        exp_lat  = exp_err ? 1 : (we ? 2 : 3);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_valid = 0;
        cyc = 1; n_wr = 0; n_rd = 0;
        while (1) begin
            if (op_code == 2'b01) n_wr++;
            if (op_code == 2'b00) n_rd++;
            if (rsp_valid || cyc >= 20) break;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_we", rsp_we, we);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_data);
        chk("write_ops", n_wr, (we && !exp_err) ? 1 : 0);
        chk("read_ops", n_rd, (!we && !exp_err) ? 1 : 0);
        got = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, exp_data);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_op", op_code, 2'b10);
            if (k < hold - 1) begin
                cmd_valid = 1; cmd_we = 1; cmd_addr = 9'($urandom_range(0, 496));
                cmd_wdata = {16{$urandom}};
            end else begin
                cmd_valid = 0; rsp_ready = 1;
            end
        end
        @(negedge clk);
        chk("rsp_cleared", rsp_valid, 0);
        chk("ready_after", cmd_ready, 1);
        if (we && !exp_err)
            for (int j = 0; j < 16; j++) ref_mem[int'(addr) + j] = wd[j*32 +: 32];
    endtask

    initial begin
        logic [511:0] got, wd;
        logic [8:0] a;
        int cyc, seen;
        for (int i = 0; i < 512; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[0] = 32'd1234; ref_mem[0] = 32'd1234;
        mem[16] = 32'd8765; ref_mem[16] = 32'd8765;
        mem_rd_data = '0;
        for (int i = 0; i < 3; i++) pipe3[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_op", op_code, 2'b10);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_wdata", mem_wr_data, 0);
        rst = 1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        txn(0, 9'd0, '0, 0, got);
        chk("t2_lane0", got[31:0], 32'd1234);
        chk("t2_upper", got[511:32], 0);
        txn(0, 9'd16, '0, 0, got);
        chk("t2_lane0_16", got[31:0], 32'd8765);

        for (int j = 0; j < 16; j++) wd[j*32 +: 32] = 32'(j + 100);
        txn(1, 9'd32, wd, 0, got);
        txn(0, 9'd32, '0, 0, got);
        chk("t1_readback", got, wd);

        txn(0, 9'd497, '0, 0, got);
        txn(0, 9'd496, '0, 0, got);
        txn(1, 9'd511, {16{32'hdead_beef}}, 0, got);

        @(negedge clk);
        c2_valid = 1; c2_addr = 9'd0;
        @(negedge clk);
        c2_valid = 0; cyc = 1;
        while (!r2_valid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("t6_latency", cyc, 5);
        chk("t6_data", r2_rdata[31:0], 32'd1234);
        chk("t6_err", r2_err, 0);

        txn(0, 9'd32, '0, 5, got);

        @(negedge clk);
        cmd_valid = 1; cmd_we = 0; cmd_addr = 9'd16;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("t5_op", op_code, 2'b10);
        chk("t5_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
        chk("t5_no_stale", seen, 0);
        chk("t5_ready", cmd_ready, 1);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: a = 9'($urandom_range(0, 511));
                1: a = 9'($urandom_range(490, 511));
                2: a = 9'($urandom_range(480, 496));
                default: a = 9'($urandom_range(0, 64));
            endcase
            for (int j = 0; j < 16; j++) wd[j*32 +: 32] = $urandom;
            txn(1'($urandom_range(0, 1)), a, wd, ($urandom_range(0, 4) == 0) ? 2 : 0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
